// File: rtl/alu_bist_pkg.sv
// Shared definitions for the ALU self-test wrapper: LFSR seed and taps,
// MISR width and tap positions, and the packed ALU result word whose field
// order is the MISR data word D (MSB first).
package alu_bist_pkg;

  localparam logic [7:0] LFSR_SEED = 8'h01;
  // x^8+x^6+x^5+x^4+1 : feedback from q[7], q[5], q[4], q[3]
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  localparam int unsigned MISR_W = 74;
  // taps 74,73,59,58 expressed as zero-based bit positions
  localparam int unsigned MISR_TAP0 = 73;
  localparam int unsigned MISR_TAP1 = 72;
  localparam int unsigned MISR_TAP2 = 58;
  localparam int unsigned MISR_TAP3 = 57;

  // Field order here defines D = {sum, cout, sub, borrow, mul, xor, xnor,
  // nand, ll, lr}; total width must equal MISR_W.
  typedef struct packed {
    logic [7:0]  sum;
    logic        cout;
    logic [7:0]  sub;
    logic        borrow;
    logic [15:0] mul;
    logic [7:0]  op_xor;
    logic [7:0]  op_xnor;
    logic [7:0]  op_nand;
    logic [7:0]  op_ll;
    logic [7:0]  op_lr;
  } alu_res_t;

  function automatic logic lfsr_feedback(input logic [7:0] q);
    return ^(q & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/alu_bist_alu8_reg.sv
// alu8_reg: registered 8-bit ALU (circuit under test). All ten results are
// captured from a_i/b_i on an enabled edge.
// Ports: clk_i, reset_i (sync, active high), en_i, a_i, b_i, res_o.
module alu8_reg
  import alu_bist_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       en_i,
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output alu_res_t   res_o
);

  alu_res_t res_q, res_d;
  logic [8:0] add_w;
  logic [8:0] sub_w;

  always_comb begin
    add_w          = {1'b0, a_i} + {1'b0, b_i};
    // bit 8 of the 9-bit difference is the unsigned borrow
    sub_w          = {1'b0, a_i} - {1'b0, b_i};
    res_d          = res_q;
    if (en_i) begin
      res_d.sum     = add_w[7:0];
      res_d.cout    = add_w[8];
      res_d.sub     = sub_w[7:0];
      res_d.borrow  = sub_w[8];
      res_d.mul     = {8'h00, a_i} * {8'h00, b_i};
      res_d.op_xor  = a_i ^ b_i;
      res_d.op_xnor = ~(a_i ^ b_i);
      res_d.op_nand = ~(a_i & b_i);
      res_d.op_ll   = {a_i[6:0], 1'b0};
      res_d.op_lr   = {1'b0, a_i[7:1]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) res_q <= '0;
    else         res_q <= res_d;
  end

  assign res_o = res_q;

endmodule

// File: rtl/alu_bist_lfsr8.sv
// lfsr8: 8-bit Fibonacci LFSR, shift left, maximal length (period 255).
// Ports: clk_i, reset_i (sync, active high), en_i (advance), q_o (state).
module lfsr8
  import alu_bist_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       en_i,
  output logic [7:0] q_o
);

  logic [7:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (en_i) q_d = {q_q[6:0], lfsr_feedback(q_q)};
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) q_q <= LFSR_SEED;
    else         q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/alu_bist_misr74.sv
// misr74: 74-bit multiple-input signature register, taps 74,73,59,58.
// Ports: clk_i, reset_i (sync, active high), en_i, data_i, sig_o.
module misr74
  import alu_bist_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              en_i,
  input  logic [MISR_W-1:0] data_i,
  output logic [MISR_W-1:0] sig_o
);

  logic [MISR_W-1:0] sig_q, sig_d;
  logic              fb;

  always_comb begin
    fb    = sig_q[MISR_TAP0] ^ sig_q[MISR_TAP1] ^ sig_q[MISR_TAP2] ^ sig_q[MISR_TAP3];
    sig_d = sig_q;
    if (en_i) sig_d = {sig_q[MISR_W-2:0], fb} ^ data_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) sig_q <= '0;
    else         sig_q <= sig_d;
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/alu_bist.sv
// alu_bist: self-test wrapper for an 8-bit ALU. LFSR operands feed a
// registered ALU whose results are compacted by a 74-bit MISR; after
// TEST_CYCLES enabled edges the run freezes and the signature is compared
// with GOLDEN.
// Ports: clk, reset (sync, active high); q (LFSR state); sum/cout, sub/borrow,
// mul, out_xor, out_xnor, out_NAND, out_LL, out_LR (registered ALU results);
// MISR (signature); done (run finished, state frozen); pass (done && match).
module alu_bist
  import alu_bist_pkg::*;
#(
  parameter logic [MISR_W-1:0] GOLDEN      = '0,
  parameter int unsigned       TEST_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  output logic [7:0]        q,
  output logic [7:0]        sum,
  output logic              cout,
  output logic [7:0]        sub,
  output logic              borrow,
  output logic [15:0]       mul,
  output logic [7:0]        out_xor,
  output logic [7:0]        out_xnor,
  output logic [7:0]        out_NAND,
  output logic [7:0]        out_LL,
  output logic [7:0]        out_LR,
  output logic [MISR_W-1:0] MISR,
  output logic              done,
  output logic              pass
);

  logic [8:0] cnt_q, cnt_d;
  logic       done_q, done_d;
  logic       run;
  alu_res_t   res;

  assign run = ~done_q;

  lfsr8 u_lfsr (
    .clk_i   (clk),
    .reset_i (reset),
    .en_i    (run),
    .q_o     (q)
  );

  alu8_reg u_alu (
    .clk_i   (clk),
    .reset_i (reset),
    .en_i    (run),
    .a_i     (q),
    .b_i     ({q[3:0], q[7:4]}),
    .res_o   (res)
  );

  misr74 u_misr (
    .clk_i   (clk),
    .reset_i (reset),
    .en_i    (run),
    .data_i  (res),
    .sig_o   (MISR)
  );

  always_comb begin
    cnt_d  = cnt_q;
    done_d = done_q;
    if (run) begin
      cnt_d  = cnt_q + 9'd1;
      done_d = (cnt_d == 9'(TEST_CYCLES));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign sum      = res.sum;
  assign cout     = res.cout;
  assign sub      = res.sub;
  assign borrow   = res.borrow;
  assign mul      = res.mul;
  assign out_xor  = res.op_xor;
  assign out_xnor = res.op_xnor;
  assign out_NAND = res.op_nand;
  assign out_LL   = res.op_ll;
  assign out_LR   = res.op_lr;
  assign done     = done_q;
  assign pass     = done_q && (MISR == GOLDEN);

endmodule

// File: tb/tb_alu_bist.sv
module tb_alu_bist;

  // ---------------- reference model (plain arithmetic) ----------------
  function automatic logic [7:0] ref_lfsr(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  function automatic logic [73:0] ref_alu(input logic [7:0] a);
    logic [7:0]  b;
    int unsigned x, y, s, p;
    logic [8:0]  s9;
    logic [7:0]  d8;
    logic [15:0] p16;
    logic        brw;
    b   = {a[3:0], a[7:4]};
    x   = a;
    y   = b;
    s   = x + y;
    p   = x * y;
    s9  = s[8:0];
    d8  = 8'((x + 256 - y) % 256);
    brw = (x < y);
    p16 = p[15:0];
    return {s9[7:0], s9[8], d8, brw, p16, a ^ b, ~(a ^ b), ~(a & b),
            8'((x * 2) % 256), 8'(x / 2)};
  endfunction

  function automatic logic [73:0] ref_misr(input logic [73:0] m, input logic [73:0] d);
    return {m[72:0], m[73] ^ m[72] ^ m[58] ^ m[57]} ^ d;
  endfunction

  function automatic logic [73:0] golden_sig();
    logic [7:0]  s;
    logic [73:0] w, m;
    s = 8'h01; w = '0; m = '0;
    for (int i = 0; i < 255; i++) begin
      m = ref_misr(m, w);
      w = ref_alu(s);
      s = ref_lfsr(s);
    end
    return m;
  endfunction

  localparam logic [73:0] GOLD = golden_sig();

  // ---------------- DUTs ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] q, sum, sub, out_xor, out_xnor, out_NAND, out_LL, out_LR;
  logic cout, borrow, done, pass;
  logic [15:0] mul;
  logic [73:0] MISR;

  logic [7:0] g_q, g_sum, g_sub, g_xor, g_xnor, g_nand, g_ll, g_lr;
  logic g_cout, g_borrow, g_done, g_pass;
  logic [15:0] g_mul;
  logic [73:0] g_MISR;

  // default GOLDEN (zero) acts as the corrupted golden value
  alu_bist dut (
    .clk(clk), .reset(reset), .q(q), .sum(sum), .cout(cout), .sub(sub),
    .borrow(borrow), .mul(mul), .out_xor(out_xor), .out_xnor(out_xnor),
    .out_NAND(out_NAND), .out_LL(out_LL), .out_LR(out_LR), .MISR(MISR),
    .done(done), .pass(pass)
  );

  alu_bist #(.GOLDEN(GOLD), .TEST_CYCLES(255)) dut_g (
    .clk(clk), .reset(reset), .q(g_q), .sum(g_sum), .cout(g_cout), .sub(g_sub),
    .borrow(g_borrow), .mul(g_mul), .out_xor(g_xor), .out_xnor(g_xnor),
    .out_NAND(g_nand), .out_LL(g_ll), .out_LR(g_lr), .MISR(g_MISR),
    .done(g_done), .pass(g_pass)
  );

  // ---------------- bench state ----------------
  int total = 0;
  int bad   = 0;

  logic [7:0]  m_q;
  logic [73:0] m_w, m_misr;
  int          m_cnt;
  logic        m_done;

  task automatic chk(input string tag, input logic [73:0] obs, input logic [73:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q = 8'h01; m_w = '0; m_misr = '0; m_cnt = 0; m_done = 1'b0;
  endtask

  task automatic check_all();
    logic [73:0] w;
    w = m_w;
    chk("q",        74'(q),        74'(m_q));
    chk("sum",      74'(sum),      74'(w[73:66]));
    chk("cout",     74'(cout),     74'(w[65]));
    chk("sub",      74'(sub),      74'(w[64:57]));
    chk("borrow",   74'(borrow),   74'(w[56]));
    chk("mul",      74'(mul),      74'(w[55:40]));
    chk("out_xor",  74'(out_xor),  74'(w[39:32]));
    chk("out_xnor", 74'(out_xnor), 74'(w[31:24]));
    chk("out_NAND", 74'(out_NAND), 74'(w[23:16]));
    chk("out_LL",   74'(out_LL),   74'(w[15:8]));
    chk("out_LR",   74'(out_LR),   74'(w[7:0]));
    chk("MISR",     MISR,          m_misr);
    chk("done",     74'(done),     74'(m_done));
    chk("pass",     74'(pass),     74'(m_done && (m_misr == 74'd0)));
    chk("g_MISR",   g_MISR,        m_misr);
    chk("g_done",   74'(g_done),   74'(m_done));
    chk("g_pass",   74'(g_pass),   74'(m_done && (m_misr == GOLD)));
  endtask

  // one clock edge: advance the model with the reset level seen at the edge
  task automatic tick();
    @(posedge clk);
    if (reset) model_reset();
    else if (!m_done) begin
      m_misr = ref_misr(m_misr, m_w);
      m_w    = ref_alu(m_q);
      m_q    = ref_lfsr(m_q);
      m_cnt++;
      if (m_cnt == 255) m_done = 1'b1;
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic run_to_done(input string tag);
    int budget;
    budget = 0;
    while (!m_done && budget < 400) begin
      tick();
      budget++;
    end
    chk(tag, 74'(done), 74'd1);
  endtask

  logic [7:0]  lfsr_tab [7];
  logic [73:0] sig_saved;
  int          rcyc;

  initial begin
    lfsr_tab = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E};
    model_reset();

    // reset
    reset = 1'b1;
    tick();
    chk("rst_q",    74'(q),    74'h01);
    chk("rst_MISR", MISR,      74'd0);
    chk("rst_done", 74'(done), 74'd0);
    reset = 1'b0;

    // first edge: ALU results for q=01, MISR still zero
    tick();
    chk("e1_q",      74'(q),        74'h02);
    chk("e1_sum",    74'(sum),      74'h11);
    chk("e1_cout",   74'(cout),     74'h0);
    chk("e1_sub",    74'(sub),      74'hF1);
    chk("e1_borrow", 74'(borrow),   74'h1);
    chk("e1_mul",    74'(mul),      74'h0010);
    chk("e1_xor",    74'(out_xor),  74'h11);
    chk("e1_xnor",   74'(out_xnor), 74'hEE);
    chk("e1_nand",   74'(out_NAND), 74'hFF);
    chk("e1_ll",     74'(out_LL),   74'h02);
    chk("e1_lr",     74'(out_LR),   74'h00);
    chk("e1_MISR",   MISR,          74'd0);

    // second edge: MISR becomes nonzero
    tick();
    chk("e2_MISR_nz", 74'(MISR != 74'd0), 74'd1);
    chk("e2_q", 74'(q), 74'(lfsr_tab[1]));

    for (int i = 2; i < 7; i++) begin
      tick();
      chk("lfsr_seq", 74'(q), 74'(lfsr_tab[i]));
    end

    // full run to completion
    run_to_done("done_timeout1");
    chk("wrap_q",  74'(q),      74'h01);
    chk("pass_bad_golden", 74'(pass), 74'd0);
    chk("pass_golden",     74'(g_pass), 74'd1);
    chk("final_sig", MISR, GOLD);
    sig_saved = m_misr;

    // frozen for 20 cycles
    for (int i = 0; i < 20; i++) tick();
    chk("hold_sig", MISR, sig_saved);

    // mid-run reset at cycle 100
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    reset = 1'b1;
    tick();
    chk("mid_rst_q",    74'(q),    74'h01);
    chk("mid_rst_MISR", MISR,      74'd0);
    chk("mid_rst_sum",  74'(sum),  74'd0);
    chk("mid_rst_done", 74'(done), 74'd0);
    reset = 1'b0;
    run_to_done("done_timeout2");
    chk("rerun_sig",  MISR,        sig_saved);
    chk("rerun_pass", 74'(g_pass), 74'd1);

    // reset at a random point in the run
    rcyc = int'($urandom_range(20, 250));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < rcyc; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    run_to_done("done_timeout3");
    chk("rand_rerun_sig", g_MISR, sig_saved);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
